serial_add_seq: RTL
===================

Name: serial_add_seq

Overview:
- Bit-serial addition sequencer: computes an N-bit sum using one external 1-bit full adder (behavioralFullAdder), one bit per clock, LSB first.
- Owns operand/result shift registers, the carry flip-flop, the bit counter and the start/done handshake.
- Sits between a requesting block and a single full-adder cell, trading latency for area.

Parameters:
- WIDTH, 8, operand/result width in bits; legal range 2..32.

Ports:
- clk  input  1  rising-edge clock
- reset_n  input  1  asynchronous active-low reset
- start  input  1  request; sampled only in IDLE
- a  input  WIDTH  operand A; captured on the accepting edge
- b  input  WIDTH  operand B; captured on the accepting edge
- cin  input  1  carry-in; captured on the accepting edge
- busy  output  1  high in RUN and DONE
- done  output  1  one-cycle completion pulse
- sum  output  WIDTH  registered result; held until the next completion
- cout  output  1  registered carry-out; held until the next completion
- fa_a  output  1  to full adder input a
- fa_b  output  1  to full adder input b
- fa_cin  output  1  to full adder carry-in
- fa_sum  input  1  from full adder sum
- fa_cout  input  1  from full adder carry-out

Behaviour:
- Reset (reset_n=0, asynchronous): state=IDLE.
  - All registers clear: shift registers, carry, counter, sum, cout.
  - busy=0, done=0, fa_*=0. Release takes effect on the next clk edge.
- FSM states: IDLE, RUN, DONE.
  - IDLE: start=1 at an edge loads a_sh<=a, b_sh<=b, carry<=cin, cnt<=0, then goes to RUN. start=0 stays in IDLE.
  - RUN: fa_a=a_sh[0], fa_b=b_sh[0], fa_cin=carry, driven combinationally from registers only. Each edge does:
    - a_sh and b_sh shift right by one, zero fill.
    - s_sh<={fa_sum, s_sh[WIDTH-1:1]}.
    - carry<=fa_cout.
    - cnt<=cnt+1.
    - On the edge where cnt==WIDTH-1: sum<={fa_sum, s_sh[WIDTH-1:1]}, cout<=fa_cout, go to DONE.
  - DONE: done=1 for exactly one cycle, then IDLE unconditionally.
- fa_a/fa_b/fa_cin are 0 in IDLE and DONE.
- Latency: call the start-accepting edge E0.
  - RUN occupies edges E1..E_WIDTH.
  - done is high from E_WIDTH to E_WIDTH+1.
  - Minimum issue period is WIDTH+2 cycles (start held high gives back-to-back operations).
- start during RUN or DONE is ignored; no queuing. a/b/cin may change freely after E0.
- sum/cout change only on the RUN-to-DONE edge; they never expose partial results.
- Arithmetic: {cout,sum} = a + b + cin, modulo 2^(WIDTH+1). There is no overflow flag.
- cnt is wide enough to hold WIDTH-1 and never wraps during an operation.
- Asynchronous reset mid-RUN or in DONE aborts the operation.
  - No done pulse follows.
  - sum/cout are cleared to 0.
- The full adder is treated as purely combinational, with settle time under one clock period.

Test Plan:
- WIDTH=8, full adder instantiated, start pulse with a=0x3C, b=0x42, cin=0.
  - busy rises after E0, done pulses at E8, sum=0x7E, cout=0.
  - fa_a/fa_b follow bits 0..7 of a/b on successive cycles.
- a=0xFF, b=0x01, cin=0 -> sum=0x00, cout=1. a=0xA5, b=0x5A, cin=1 -> sum=0x00, cout=1. a=0x00, b=0x00, cin=0 -> sum=0x00, cout=0.
- start held high with operands changing every cycle:
  - Operations are accepted exactly every 10 cycles.
  - Each result matches the operands present at its accepting edge.
  - Mid-run operand changes do not affect the result.
- Extra start pulses at RUN cycles 3 and 7 plus one during DONE -> no restart, exactly one done pulse, correct result.
- Assert reset_n=0 asynchronously (between edges) 4 cycles into RUN -> busy/done/sum/cout/fa_* go to 0 immediately with no clock. After release: no done pulse and stays IDLE until the next start.
- After a completed operation, hold start=0 for 20 cycles -> sum/cout stay stable, done stays 0, fa_* stay 0.

Source files
------------

// File: rtl/serial_add_seq.sv
// Bit-serial adder sequencer: drives one external full-adder cell
// LSB first, one bit per clock, and owns the operand/result shifters.
module serial_add_seq #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             fa_a,
    output logic             fa_b,
    output logic             fa_cin,
    input  logic             fa_sum,
    input  logic             fa_cout
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t st;
    state_t nxt;

    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-2:0] s_sh;
    logic [WIDTH-1:0] s_nxt;
    logic             carry;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] sum_q;
    logic             cout_q;

    logic load;
    logic step;
    logic last;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            st <= S_IDLE;
        end else begin
            st <= nxt;
        end
    end

    always_comb begin
        nxt  = st;
        load = 1'b0;
        step = 1'b0;
        last = 1'b0;
        unique case (st)
            S_IDLE: begin
                if (start) begin
                    load = 1'b1;
                    nxt  = S_RUN;
                end
            end
            S_RUN: begin
                step = 1'b1;
                if (cnt == LAST) begin
                    last = 1'b1;
                    nxt  = S_DONE;
                end
            end
            S_DONE: begin
                nxt = S_IDLE;
            end
            default: begin
                nxt = S_IDLE;
            end
        endcase
    end

    // The newest result bit enters at the top; after WIDTH steps the
    // first bit computed has reached bit 0 of the assembled word.
    assign s_nxt = {fa_sum, s_sh};

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            a_sh   <= '0;
            b_sh   <= '0;
            s_sh   <= '0;
            carry  <= 1'b0;
            cnt    <= '0;
            sum_q  <= '0;
            cout_q <= 1'b0;
        end else if (load) begin
            a_sh  <= a;
            b_sh  <= b;
            carry <= cin;
            cnt   <= '0;
        end else if (step) begin
            a_sh  <= a_sh >> 1;
            b_sh  <= b_sh >> 1;
            s_sh  <= s_nxt[WIDTH-1:1];
            carry <= fa_cout;
            cnt   <= cnt + 1'b1;
            if (last) begin
                sum_q  <= s_nxt;
                cout_q <= fa_cout;
            end
        end
    end

    assign busy   = (st == S_RUN) || (st == S_DONE);
    assign done   = (st == S_DONE);
    assign sum    = sum_q;
    assign cout   = cout_q;
    assign fa_a   = (st == S_RUN) & a_sh[0];
    assign fa_b   = (st == S_RUN) & b_sh[0];
    assign fa_cin = (st == S_RUN) & carry;

endmodule
